// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits complete in the request cycle out of LUT-RAM. A miss stalls the CPU
// through `miss`, optionally writes the dirty victim back, refills the line,
// and then lets the held request complete as a hit.
module dcache #(
  parameter int INDEX_W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  input  logic         write_enable,
  input  logic         read_enable,
  output logic [31:0]  rdata,
  output logic         miss,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack,
  output logic [31:0]  miss_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  // Line state and storage
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][4];

  // Controller and memory-port registers
  logic [1:0]   state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic [31:0]  miss_count_q, miss_count_d;

  // Address fields
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         off;
  logic [31:0]        line_addr;
  logic               unused_addr;

  assign idx         = addr[3+INDEX_W:4];
  assign req_tag     = addr[31:4+INDEX_W];
  assign off         = addr[3:2];
  assign line_addr   = {addr[31:4], 4'b0000};
  assign unused_addr = ^addr[1:0];

  // Lookup
  logic req, hit, wr_hit, wb_done, fill_done;

  assign req       = read_enable || write_enable;
  assign hit       = (state_q == S_IDLE) && valid_q[idx] && (tag_q[idx] == req_tag);
  assign miss      = req && !hit;
  assign wr_hit    = write_enable && hit;
  assign wb_done   = (state_q == S_WB) && mem_ack;
  assign fill_done = (state_q == S_FILL) && mem_ack;

  // Read data comes straight out of the array; a same-cycle store lands at the edge.
  assign rdata = data_q[idx][off];

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign miss_count = miss_count_q;

  // Next-state logic for the miss controller and the registered memory port.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    miss_count_d = miss_count_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          mem_req_d = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = S_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx], idx, 4'b0000};
            mem_wdata_d = {data_q[idx][3], data_q[idx][2], data_q[idx][1], data_q[idx][0]};
          end else begin
            state_d    = S_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = line_addr;
          end
        end
      end
      S_WB: begin
        if (mem_ack) begin
          // mem_req stays high straight into the refill
          state_d    = S_FILL;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rstn) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 128'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Valid/dirty bookkeeping: set dirty on store hit, clear on writeback/refill.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[idx] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Data and tag arrays: store hits and line refills.
  always_ff @(posedge clk) begin
    // NOTE: the arrays carry no reset; cleared valid bits make their contents irrelevant.
    if (wr_hit) begin
      data_q[idx][off] <= wdata;
    end
    if (fill_done) begin
      for (int w = 0; w < 4; w++) begin
        data_q[idx][w] <= mem_rdata[32*w +: 32];
      end
      tag_q[idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed scenarios plus randomized loads/stores against a
// behavioural model of architectural memory, backing memory and residency.
module tb_dcache;

  localparam int INDEX_W = 6;
  localparam int LINES   = 1 << INDEX_W;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         write_enable;
  logic         read_enable;
  logic [31:0]  rdata;
  logic         miss;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  miss_count;

  dcache #(.INDEX_W(INDEX_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .addr         (addr),
    .wdata        (wdata),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .rdata        (rdata),
    .miss         (miss),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: backing memory by line, CPU-visible stores by word,
  // and which line address each index currently holds.
  logic [127:0] backing [logic [31:0]];
  logic [31:0]  arch    [logic [31:0]];
  bit           res_valid [LINES];
  bit           res_dirty [LINES];
  logic [31:0]  res_line  [LINES];
  int unsigned  exp_misses;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] backing_line(input logic [31:0] l);
    if (backing.exists(l)) return backing[l];
    if (l == 32'h40) return {32'd4, 32'd3, 32'd2, 32'd1};
    return {l ^ 32'h3C3C_0003, l ^ 32'h5A5A_0002, l * 32'd3, ~l};
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [127:0] ln;
    wa = {a[31:2], 2'b00};
    if (arch.exists(wa)) return arch[wa];
    ln = backing_line({a[31:4], 4'b0000});
    return ln[32*a[3:2] +: 32];
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] l);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = model_word(l + 32'(4*w));
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
    end
    arch.delete();
    exp_misses = 0;
  endfunction

  // Hold the request for a random number of cycles, then pulse mem_ack once.
  // Entered and left on a negedge.
  task automatic handshake();
    int dly;
    dly = $urandom_range(0, 3);
    repeat (dly) begin
      @(negedge clk);
      check("hold_req", mem_req, 1'b1);
      check("hold_miss", miss, 1'b1);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  // One CPU access, started just after a posedge and left just after a posedge.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] line;
    logic [31:0] victim;
    int          idx;
    bit          exp_hit;
    line = {a[31:4], 4'b0000};
    idx  = int'((a >> 4) & 32'(LINES - 1));
    write_enable = w;
    read_enable  = r;
    addr         = a;
    wdata        = d;
    if (!(w || r)) begin
      mem_ack = 1'b1;
      @(negedge clk);
      check("miss_noreq", miss, 1'b0);
      check("req_noreq", mem_req, 1'b0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      check("req_after_idle_ack", mem_req, 1'b0);
      return;
    end
    @(negedge clk);
    exp_hit = res_valid[idx] && (res_line[idx] == line);
    check("miss", miss, !exp_hit);
    if (!exp_hit) begin
      if (res_valid[idx] && res_dirty[idx]) begin
        victim = res_line[idx];
        @(negedge clk);
        check("wb_req", mem_req, 1'b1);
        check("wb_we", mem_we, 1'b1);
        check("wb_addr", mem_addr, victim);
        check("wb_data", mem_wdata, model_line(victim));
        backing[victim] = mem_wdata;
        handshake();
        res_dirty[idx] = 1'b0;
      end else begin
        @(negedge clk);
      end
      check("fill_req", mem_req, 1'b1);
      check("fill_we", mem_we, 1'b0);
      check("fill_addr", mem_addr, line);
      check("fill_miss", miss, 1'b1);
      mem_rdata = backing_line(line);
      handshake();
      res_valid[idx] = 1'b1;
      res_dirty[idx] = 1'b0;
      res_line[idx]  = line;
      if (exp_misses != 32'hFFFF_FFFF) exp_misses++;
      check("miss_after_fill", miss, 1'b0);
    end
    check("req_idle", mem_req, 1'b0);
    if (r) check("rdata", rdata, model_word(a));
    @(posedge clk);
    if (w) begin
      arch[{a[31:2], 2'b00}] = d;
      res_dirty[idx] = 1'b1;
    end
    #1;
    check("miss_count", miss_count, exp_misses);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    rstn         = 1'b0;
    addr         = 32'd0;
    wdata        = 32'd0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    mem_rdata    = 128'd0;
    mem_ack      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 128'd0);
    check("rst_count", miss_count, 32'd0);
    check("rst_miss", miss, 1'b0);
    @(posedge clk);
    #1;

    // Cold read, then hits on the rest of the line
    access(1'b0, 1'b1, 32'h40, 32'd0);
    access(1'b0, 1'b1, 32'h44, 32'd0);
    access(1'b0, 1'b1, 32'h48, 32'd0);
    access(1'b0, 1'b1, 32'h4C, 32'd0);
    check("cold_read_val", model_word(32'h40), 32'd1);

    // Store hit, then a conflicting read forces writeback of the dirty line
    access(1'b1, 1'b0, 32'h44, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h40 + (32'd16 << INDEX_W), 32'd0);

    // Write-miss allocate, then read it back
    access(1'b1, 1'b0, 32'h300, 32'h1234_5678);
    access(1'b0, 1'b1, 32'h300, 32'd0);

    // Simultaneous read and write: old word visible, new word next time
    access(1'b0, 1'b1, 32'h44, 32'd0);
    access(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D);
    access(1'b0, 1'b1, 32'h44, 32'd0);

    // Idle cycle with a stray mem_ack
    access(1'b0, 1'b0, 32'h0, 32'd0);

    // Reset while a refill is outstanding
    write_enable = 1'b0;
    read_enable  = 1'b1;
    addr         = 32'h500;
    @(negedge clk);
    check("rstfill_miss", miss, 1'b1);
    @(negedge clk);
    check("rstfill_req", mem_req, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("rstfill_req_drop", mem_req, 1'b0);
    check("rstfill_count", miss_count, 32'd0);
    rstn        = 1'b1;
    read_enable = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    access(1'b0, 1'b1, 32'h300, 32'd0);

    // Randomized traffic over a few indices and tags to provoke conflicts
    for (int i = 0; i < 400; i++) begin
      a = (32'($urandom_range(0, 3)) << (4 + INDEX_W))
        | (32'($urandom_range(0, 4)) << 4)
        | (32'($urandom_range(0, 3)) << 2)
        | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 7);
      case (op)
        0:       access(1'b0, 1'b0, a, 32'd0);
        1, 2, 3: access(1'b0, 1'b1, a, 32'd0);
        4, 5, 6: access(1'b1, 1'b0, a, $urandom);
        default: access(1'b1, 1'b1, a, $urandom);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and the external line-based memory controller. It serves 32-bit word loads and stores in one cycle on a hit. On a miss it stalls the CPU through `miss`, writes back the victim line if dirty, refills the line, then completes the access. Storage is LUT-RAM, so hit data is combinational.

## Interface
Parameters:
- `INDEX_W`, default 6: index width; 2^INDEX_W lines of 4 words (16 bytes) each.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `addr`  in  32  CPU byte address; [3:2] word offset, [3+INDEX_W:4] index, [31:4+INDEX_W] tag; [1:0] ignored
- `wdata`  in  32  CPU store data
- `write_enable`  in  1  CPU store request
- `read_enable`  in  1  CPU load request
- `rdata`  out  32  load data; valid only when `read_enable` && !`miss`
- `miss`  out  1  combinational stall; CPU holds addr/wdata/enables stable while high
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = line write (writeback), 0 = line read (refill); registered
- `mem_addr`  out  32  line-aligned address, [3:0]=0; registered
- `mem_wdata`  out  128  writeback line; word 0 in [31:0]; registered
- `mem_rdata`  in  128  refill line; same word ordering as `mem_wdata`
- `mem_ack`  in  1  one-cycle pulse ending the current request
- `miss_count`  out  32  saturating count of serviced misses

## Operation
- Per line: valid, dirty, tag (32-4-INDEX_W bits), 4×32 data.
- Hit means state IDLE && valid[idx] && tag[idx]==addr tag.
- `miss` = (read_enable || write_enable) && !hit. It is forced 1 in any state other than IDLE while a request is present. It is 0 with no request.
- Read hit: `rdata` = data[idx][addr[3:2]], combinational.
- Write hit: data[idx][addr[3:2]] <= wdata at the posedge; dirty[idx] <= 1.
- If both enables are high, the write takes priority. `rdata` shows the pre-write word.
- FSM states: IDLE, WB, FILL.
  - IDLE → WB: request misses and line is valid && dirty. Load mem_req=1, mem_we=1, mem_addr={old tag, idx, 4'b0}, mem_wdata=line data.
  - IDLE → FILL: request misses and line is invalid or clean. Load mem_req=1, mem_we=0, mem_addr={addr[31:4], 4'b0}.
  - WB, on mem_ack → FILL: mem_we=0, mem_addr={addr[31:4],4'b0}; mem_req stays 1. Dirty is cleared.
  - FILL, on mem_ack → IDLE: data[idx]<=mem_rdata, tag<=addr tag, valid<=1, dirty<=0, mem_req<=0. miss_count increments, saturating at 32'hFFFFFFFF.
- After returning to IDLE, the held request hits and completes normally; a store is written into the freshly filled line.
- A `mem_ack` received in IDLE is ignored.
- Reset: all valid and dirty bits cleared; state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, miss_count=0. Data and tag arrays are not reset.
- Reset during WB/FILL: the transfer is abandoned and mem_req drops in the next cycle. The memory controller is reset with the same `rstn`.

## Timing
- Hit: 0 extra cycles; miss=0 in the request cycle.
- Clean miss:
  - Cycle 0: request seen, miss=1.
  - Cycle 1: mem_req=1.
  - Cycle A: mem_ack (A ≥ 1).
  - Cycle A+1: IDLE, miss=0, access completes.
- Dirty miss: the WB handshake is inserted first. mem_req stays high continuously across the WB→FILL transition, with mem_we falling in the cycle after the WB ack.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from assertion until the cycle after `mem_ack`.
- `miss` is combinational from addr/enables and state. The CPU must not feed it back combinationally into addr.

## Test plan
- Cold read: reset, then read 0x0000_0040. Expect: miss=1; mem_req with mem_we=0, mem_addr=0x40. Return mem_rdata={4,3,2,1} with ack 3 cycles later. Next cycle miss=0, rdata=1. miss_count=1.
- Read hit sequence: after the refill above, read 0x44, 0x48, 0x4C on consecutive cycles. Expect miss=0 every cycle, rdata=2, 3, 4, and no mem_req.
- Write hit then dirty eviction:
  - Write 0xDEADBEEF to 0x44, which is a hit (miss=0, no mem_req).
  - Then read 0x40+(16<<INDEX_W), same index, different tag.
  - Expect WB: mem_we=1, mem_addr=0x40, mem_wdata[63:32]=0xDEADBEEF.
  - Then FILL to the new address; miss falls the cycle after the FILL ack.
- Write miss allocate: store 0x12345678 to a cold line. Expect FILL only (no WB), then the store completes. A later read of the same address returns 0x12345678 with miss=0.
- Reset mid-FILL: assert rstn=0 while mem_req=1. Next cycle mem_req=0 and miss_count=0. A read of the previously cached address misses.
- Simultaneous read+write hit to 0x44: rdata = old word in that cycle; the next read returns the new word.
